// File: rtl/polar_pkg.sv
// Shared polar-code definitions: FSM states, default code parameters and index helpers.
package polar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ENCODE,
    SEND
  } state_t;

  localparam int DEFAULT_N = 8;
  localparam logic [DEFAULT_N-1:0] DEFAULT_FROZEN_MASK = 8'b0001_0111;

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int bitrev(input int value, input int nbits);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (i < nbits) r = (r << 1) | ((value >> i) & 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// One stage of the polar transform: v[j] ^= v[j + 2^s] for every j with bit s of j clear.
module polar_butterfly_stage
  import polar_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter int LOGN = log2_ceil(N)
) (
  input  logic [N-1:0]    v,
  input  logic [LOGN-1:0] s,
  output logic [N-1:0]    v_next
);

  // Each stage is unrolled with constant indices; the runtime stage index picks one.
  always_comb begin
    v_next = v;
    for (int st = 0; st < LOGN; st++) begin
      if (s == LOGN'(st)) begin
        for (int j = 0; j < N; j++) begin
          if ((((j >> st) & 1) == 0) && ((j + (1 << st)) < N)) begin
            v_next[j] = v[j] ^ v[j + (1 << st)];
          end
        end
      end
    end
  end

endmodule

// File: rtl/polar_encoder.sv
// Sequential polar encoder: serial info bits in, one butterfly stage per clock, serial codeword out.
// Define POLAR_ENC_BITREV_EN to emit the codeword in bit-reversed order.
module polar_encoder
  import polar_pkg::*;
#(
  parameter int           N           = DEFAULT_N,
  parameter logic [N-1:0] FROZEN_MASK = DEFAULT_FROZEN_MASK
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last,
  output logic busy
);

  localparam int LOGN = log2_ceil(N);
  localparam int K    = N - $countones(FROZEN_MASK);
  localparam int CW   = LOGN + 1;

  generate
    if (N < 2 || N > 1024 || (1 << LOGN) != N) begin : g_bad_n
      $error("polar_encoder: N must be a power of two in 2..1024");
    end
    if (K < 1) begin : g_bad_k
      $error("polar_encoder: FROZEN_MASK leaves no information positions");
    end
  endgenerate

  state_t          state, next_state;
  logic [N-1:0]    v, v_next;
  logic [CW-1:0]   cnt;
  logic [LOGN-1:0] stage, beat, wr_idx, rd_idx;

  polar_butterfly_stage #(.N(N), .LOGN(LOGN)) u_stage (
    .v      (v),
    .s      (stage),
    .v_next (v_next)
  );

  // The cnt-th unfrozen position, scanning upward from index 0.
  always_comb begin
    int seen;
    seen   = 0;
    wr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!FROZEN_MASK[i]) begin
        if (seen == int'(cnt)) wr_idx = LOGN'(i);
        seen++;
      end
    end
  end

`ifdef POLAR_ENC_BITREV_EN
  assign rd_idx = LOGN'(bitrev(int'(beat), LOGN));
`else
  assign rd_idx = beat;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: next_state = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == CW'(K - 1)) next_state = ENCODE;
      end
      ENCODE: begin
        busy = 1'b1;
        if (stage == LOGN'(LOGN - 1)) next_state = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && beat == LOGN'(N - 1)) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  assign out_bit  = (state == SEND) && v[rd_idx];
  assign out_last = (state == SEND) && (beat == LOGN'(N - 1));

  // Frozen positions are never written, so they stay at the zero left by reset or frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      cnt   <= '0;
      stage <= '0;
      beat  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            v[wr_idx] <= in_bit;
            cnt       <= (cnt == CW'(K - 1)) ? '0 : cnt + CW'(1);
            stage     <= '0;
          end
        end
        ENCODE: begin
          v     <= v_next;
          stage <= stage + LOGN'(1);
          beat  <= '0;
        end
        SEND: begin
          if (out_ready) begin
            if (beat == LOGN'(N - 1)) begin
              beat <= '0;
              v    <= '0;
            end else begin
              beat <= beat + LOGN'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/polar_encoder.md
# polar_encoder

Sequential polar encoder, the transmit-side counterpart of the successive-cancellation decoder and its 2-bit P-node leaf. It accepts K information bits serially and places them into the non-frozen positions of an N-bit u vector. It applies the polar transform x = u·F^⊗n with F = [[1,0],[1,1]], one butterfly stage per clock, and streams the N codeword bits out with a valid/ready handshake. At N=2 it reproduces the P-node relation x0 = u0^u1, x1 = u1.

## Interface
- N, 8, codeword length; power of two, 2..1024; n = log2(N)
- FROZEN_MASK, 8'b0001_0111, bit i = 1 means u[i] is frozen to 0; K = N − popcount(FROZEN_MASK), K ≥ 1 (elaboration error otherwise)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  info bit present
- in_ready  out  1  encoder accepts info bit
- in_bit  in  1  info bit, lowest unfrozen index first
- out_valid  out  1  codeword bit present
- out_ready  in  1  sink accepts codeword bit
- out_bit  out  1  codeword bit
- out_last  out  1  high with the final (N-th) codeword bit
- busy  out  1  high in ENCODE or SEND

## Operation
- States: IDLE, LOAD, ENCODE, SEND.
- IDLE → LOAD unconditionally on the first edge after reset release.
- LOAD:
  - in_ready=1; each in_valid&&in_ready writes in_bit to the next unfrozen index of u (ascending index).
  - Frozen positions are held at 0.
  - After the K-th accept → ENCODE; stage counter = 0.
- ENCODE, one stage s per edge (s = 0..n−1): for every j with bit s of j = 0, v[j] ← v[j] ^ v[j+2^s]; v[j+2^s] unchanged. After stage n−1 → SEND; beat counter = 0.
- SEND:
  - out_valid=1; out_bit = x[beat], out_last = (beat == N−1).
  - On out_valid&&out_ready the beat increments.
  - On the last accepted beat → LOAD, and u and v are cleared.
- in_valid outside LOAD is ignored; the source must hold its bit until in_ready.
- out_bit and out_last stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: in_ready=0, out_valid=0, out_bit=0, out_last=0, busy=0. State=IDLE; u, v, all counters = 0.
- in_ready=1 from the first edge after rst deassertion.
- Latency: out_valid rises exactly n edges after the edge that accepts the K-th info bit (N=8: 3 cycles).
- Throughput: one info bit per cycle in, one codeword bit per cycle out. Frame period with no stalls = K + n + N cycles.
- After the edge that accepts the out_last beat: in_ready=1 and out_valid=0 on the next cycle. No overlap between frames.
- Reset mid-operation, in any state: the partial frame is discarded and all outputs return to reset values asynchronously.
- K = N (mask all zero): LOAD lasts N accepts; otherwise identical.

## Configuration
- POLAR_ENC_BITREV_EN defined: SEND emits x[bitrev_n(beat)], i.e. bit-reversed codeword order, matching decoders that expect bit-reversed input. out_last is still the N-th beat.
- Not defined: natural order x[0..N−1].

## Structure
- polar_pkg holds:
  - the state enum (IDLE, LOAD, ENCODE, SEND);
  - the log2 helper and the bitrev function;
  - the default N and FROZEN_MASK constants shared with the decoder.
- One sub-module, polar_butterfly_stage: combinational, parameter N, input v and stage index s, output the updated v. The encoder instantiates it once and registers its result.

## Test plan
Scenarios 1–5 use N=8 and the default mask; the info positions are 3, 5, 6, 7.
1. Reset, then info 1,0,0,0 → after 3 cycles, out bits 1,1,1,1,0,0,0,0; out_last on the 8th bit.
2. Info 1,1,1,1 → out 0,1,1,0,1,0,0,1; with POLAR_ENC_BITREV_EN, info 1,0,0,0 → out 1,0,1,0,1,0,1,0.
3. Random out_ready, low about 50% of cycles → same codeword as with no stalls. out_bit and out_last stable during stalls; exactly 8 beats.
4. in_valid held high during ENCODE/SEND with toggling data → ignored; the next frame encodes only bits accepted after in_ready returns.
5. rst asserted after the 2nd info bit and again at SEND beat 4 → outputs return to reset values immediately. A fresh frame 1,0,0,0 then yields scenario 1's codeword.
6. N=2, FROZEN_MASK=0: info u0=1, u1=1 → out 0,1; info 0,1 → out 1,1 (the P-node relation).
